// File: rtl/debounce_events_pkg.sv
// Shared constants for the debounce_events block: FSM state encodings and
// the hold-off value substituted when the programmed wait is zero.
package debounce_events_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  localparam int unsigned WAIT_MIN = 1;

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchroniser for W asynchronous bits, reset to a programmable value.
module bit_sync2 #(
  parameter int         W     = 1,
  parameter logic [W-1:0] INITV = '0
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta_q <= INITV;
      sync_q <= INITV;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/debounce_events.sv
// Multi-channel debouncer with one shared hold-off timer, per-channel
// press/release strobes and a sticky write-1-to-clear event register.
module debounce_events
  import debounce_events_pkg::*;
#(
  parameter int           NIN        = 21,
  parameter int           LGWAIT     = 17,
  parameter bit           ACTIVE_LOW = 1'b0,
  parameter logic [NIN-1:0] INITV    = '0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NIN-1:0]    i_in,
  input  logic [LGWAIT-1:0] i_wait,
  input  logic [NIN-1:0]    i_clear,
  output logic [NIN-1:0]    o_debounced,
  output logic [NIN-1:0]    o_rise,
  output logic [NIN-1:0]    o_fall,
  output logic [NIN-1:0]    o_events,
  output logic              o_int,
  output logic              o_busy
);

  logic [NIN-1:0]    x;
  logic [NIN-1:0]    s;
  logic              state_q, state_d;
  logic [LGWAIT-1:0] timer_q, timer_d;
  logic [NIN-1:0]    deb_q, deb_d;
  logic [NIN-1:0]    rise_q, rise_d;
  logic [NIN-1:0]    fall_q, fall_d;
  logic [NIN-1:0]    events_q, events_d;
  logic              int_q, int_d;

  assign x = ACTIVE_LOW ? ~i_in : i_in;

  bit_sync2 #(
    .W     (NIN),
    .INITV (INITV)
  ) u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (x),
    .o_q       (s)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    deb_d   = deb_q;
    rise_d  = '0;
    fall_d  = '0;
    if (state_q == ST_IDLE) begin
      if (s != deb_q) begin
        deb_d   = s;
        rise_d  = s & ~deb_q;
        fall_d  = ~s & deb_q;
        timer_d = (i_wait == '0) ? LGWAIT'(WAIT_MIN) : i_wait;
        state_d = ST_WAIT;
      end
    end else begin
      // Guarding with <= keeps the count from wrapping even if the timer were ever 0 here.
      if (timer_q <= LGWAIT'(1)) begin
        timer_d = '0;
        state_d = ST_IDLE;
      end else begin
        timer_d = timer_q - LGWAIT'(1);
      end
    end
    // Both the commit-cycle strobes and the visible strobes set, so a clear never beats a new edge.
    events_d = (events_q & ~i_clear) | rise_q | fall_q | rise_d | fall_d;
    int_d    = |events_d;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      deb_q    <= INITV;
      rise_q   <= '0;
      fall_q   <= '0;
      events_q <= '0;
      int_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      deb_q    <= deb_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      events_q <= events_d;
      int_q    <= int_d;
    end
  end

  assign o_debounced = deb_q;
  assign o_rise      = rise_q;
  assign o_fall      = fall_q;
  assign o_events    = events_q;
  assign o_int       = int_q;
  assign o_busy      = (state_q == ST_WAIT);

endmodule

// File: tb/tb_debounce_events.sv
// Directed bench for debounce_events: a default-parameter instance and a
// small active-low instance with a 6-bit timer.
module tb_debounce_events;

  localparam int NA = 21;
  localparam int LA = 17;
  localparam int NB = 8;
  localparam int LB = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a_n, rst_b_n;
  logic [NA-1:0] in_a, clear_a, deb_a, rise_a, fall_a, ev_a;
  logic [LA-1:0] wait_a;
  logic          int_a, busy_a;
  logic [NB-1:0] in_b, clear_b, deb_b, rise_b, fall_b, ev_b;
  logic [LB-1:0] wait_b;
  logic          int_b, busy_b;

  int total = 0;
  int bad   = 0;

  debounce_events dut_a (
    .i_clk       (clk),
    .i_reset_n   (rst_a_n),
    .i_in        (in_a),
    .i_wait      (wait_a),
    .i_clear     (clear_a),
    .o_debounced (deb_a),
    .o_rise      (rise_a),
    .o_fall      (fall_a),
    .o_events    (ev_a),
    .o_int       (int_a),
    .o_busy      (busy_a)
  );

  debounce_events #(
    .NIN        (NB),
    .LGWAIT     (LB),
    .ACTIVE_LOW (1'b1),
    .INITV      ('0)
  ) dut_b (
    .i_clk       (clk),
    .i_reset_n   (rst_b_n),
    .i_in        (in_b),
    .i_wait      (wait_b),
    .i_clear     (clear_b),
    .o_debounced (deb_b),
    .o_rise      (rise_b),
    .o_fall      (fall_b),
    .o_events    (ev_b),
    .o_int       (int_b),
    .o_busy      (busy_b)
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts consecutive samples with busy high, starting with the current one.
  task automatic count_busy(input bit sel_b, output int n);
    n = 0;
    while (n < 200 && (sel_b ? busy_b : busy_a)) begin
      n++;
      tick(1);
    end
  endtask

  task automatic wait_idle_a();
    int g;
    g = 0;
    while (busy_a && g < 300) begin
      tick(1);
      g++;
    end
    if (busy_a) check_output("idle_timeout", 32'(busy_a), 32'd0);
  endtask

  initial begin
    int n, k, nr, nf;
    in_a    = '0;
    clear_a = '0;
    wait_a  = LA'(8);
    rst_a_n = 1'b0;
    in_b    = '1;
    clear_b = '0;
    wait_b  = 6'h3F;
    rst_b_n = 1'b0;
    #12;
    check_output("in_rst_busy", 32'(busy_a), 32'd0);
    check_output("in_rst_deb", 32'(deb_a), 32'd0);
    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    tick(3);
    check_output("rst_deb", 32'(deb_a), 32'd0);
    check_output("rst_rise", 32'(rise_a), 32'd0);
    check_output("rst_ev", 32'(ev_a), 32'd0);
    check_output("rst_int", 32'(int_a), 32'd0);
    check_output("rst_busy", 32'(busy_a), 32'd0);
    check_output("al_no_events", 32'(ev_b), 32'd0);
    check_output("al_deb_idle", 32'(deb_b), 32'd0);
    check_output("al_busy_idle", 32'(busy_b), 32'd0);

    $display("[TB] basic rise, wait=8");
    in_a[0] = 1'b1;
    tick(2);
    check_output("lat2_deb", 32'(deb_a), 32'd0);
    tick(1);
    check_output("lat3_deb", 32'(deb_a), 32'h1);
    check_output("lat3_rise", 32'(rise_a), 32'h1);
    check_output("lat3_fall", 32'(fall_a), 32'h0);
    check_output("lat3_ev", 32'(ev_a), 32'h1);
    check_output("lat3_int", 32'(int_a), 32'd1);
    check_output("lat3_busy", 32'(busy_a), 32'd1);
    tick(1);
    check_output("rise_one_cycle", 32'(rise_a), 32'h0);
    count_busy(1'b0, n);
    check_output("busy_w8", 32'(n + 1), 32'd8);

    $display("[TB] clear behaviour");
    clear_a = NA'(1);
    tick(1);
    clear_a = '0;
    check_output("clr_ev", 32'(ev_a), 32'h0);
    check_output("clr_int", 32'(int_a), 32'd0);
    clear_a = '1;
    tick(1);
    clear_a = '0;
    check_output("clr_noop_ev", 32'(ev_a), 32'h0);
    check_output("clr_noop_deb", 32'(deb_a), 32'h1);
    in_a[0] = 1'b0;
    tick(3);
    check_output("race_fall", 32'(fall_a), 32'h1);
    clear_a = NA'(1);
    tick(1);
    clear_a = '0;
    check_output("race_set_wins", 32'(ev_a), 32'h1);
    check_output("race_int", 32'(int_a), 32'd1);
    clear_a = NA'(1);
    tick(1);
    clear_a = '0;
    check_output("lone_clr_ev", 32'(ev_a), 32'h0);
    check_output("lone_clr_int", 32'(int_a), 32'd0);
    wait_idle_a();

    $display("[TB] bounce on bit 1");
    nr = 0;
    nf = 0;
    in_a[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) in_a[1] = 1'b0;
      if (i == 4) in_a[1] = 1'b1;
      tick(1);
      nr += int'(rise_a[1]);
      nf += int'(fall_a[1]);
      if (i == 15) check_output("bounce_final", 32'(deb_a[1]), 32'd1);
    end
    check_output("bounce_rises", 32'(nr), 32'd1);
    check_output("bounce_falls", 32'(nf), 32'd0);
    wait_idle_a();
    clear_a = '1;
    tick(1);
    clear_a = '0;

    $display("[TB] change during wait");
    in_a[0] = 1'b1;
    tick(3);
    check_output("dw_rise0", 32'(rise_a), 32'h1);
    tick(1);
    in_a[2] = 1'b1;
    k = 1;
    while (!rise_a[2] && k < 40) begin
      tick(1);
      k++;
    end
    check_output("dw_spacing", 32'(k), 32'd9);
    check_output("dw_ev", 32'(ev_a), 32'h5);
    check_output("dw_int", 32'(int_a), 32'd1);
    tick(1);
    wait_a = LA'(3);
    count_busy(1'b0, n);
    check_output("wait_change_ignored", 32'(n), 32'd7);

    in_a[20] = 1'b1;
    tick(3);
    check_output("w3_rise20", 32'(rise_a), 32'h100000);
    count_busy(1'b0, n);
    check_output("busy_w3", 32'(n), 32'd3);

    wait_a = '0;
    in_a[0] = 1'b0;
    in_a[2] = 1'b0;
    tick(3);
    check_output("w0_fall", 32'(fall_a), 32'h5);
    check_output("w0_deb", 32'(deb_a), 32'h100002);
    count_busy(1'b0, n);
    check_output("busy_w0", 32'(n), 32'd1);

    $display("[TB] active-low instance");
    in_b[4] = 1'b0;
    tick(3);
    check_output("al_rise4", 32'(rise_b), 32'h10);
    check_output("al_deb4", 32'(deb_b), 32'h10);
    count_busy(1'b1, n);
    check_output("al_busy_max", 32'(n), 32'd63);
    in_b[4] = 1'b1;
    tick(3);
    check_output("al_fall4", 32'(fall_b), 32'h10);
    check_output("pre_rst_busy", 32'(busy_b), 32'd1);
    #2;
    rst_b_n = 1'b0;
    #1;
    check_output("arst_busy", 32'(busy_b), 32'd0);
    check_output("arst_fall", 32'(fall_b), 32'h0);
    check_output("arst_ev", 32'(ev_b), 32'h0);
    check_output("arst_int", 32'(int_b), 32'd0);
    check_output("arst_deb", 32'(deb_b), 32'h0);
    @(negedge clk);
    rst_b_n = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
